// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges in-order results (A) with FIFO-buffered long-latency results (B)
// into one registered regfile write per cycle. Define WB_FAIR_EN to enable the starvation guard.
`timescale 1ns/1ps
module wb_arbiter #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      a_valid,
   output logic                      a_ready,
   input  logic [4:0]                a_reg,
   input  logic [31:0]               a_data,
   input  logic                      b_valid,
   output logic                      b_ready,
   input  logic [4:0]                b_reg,
   input  logic [31:0]               b_data,
   output logic                      regwrite,
   output logic [4:0]                wreg,
   output logic [31:0]               wdata,
   input  logic [4:0]                qreg,
   output logic                      qpending,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_param
      $error("wb_arbiter: DEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
   end

   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [4:0]    fifo_reg_q  [DEPTH];
   logic [4:0]    fifo_reg_d  [DEPTH];
   logic [31:0]   fifo_data_q [DEPTH];
   logic [31:0]   fifo_data_d [DEPTH];
   logic          regwrite_q, regwrite_d;
   logic [4:0]    wreg_q, wreg_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          a_win, drain, enq, force_b;

`ifdef WB_FAIR_EN
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   logic [WW-1:0] wait_q, wait_d;

   // Counter only advances while the FIFO holds something, so reaching MAX_WAIT implies a head exists.
   assign force_b = (wait_q == WW'(MAX_WAIT)) && (count_q != '0);

   always_comb begin
      wait_d = wait_q;
      if (drain)
         wait_d = '0;
      else if (count_q != '0 && wait_q != WW'(MAX_WAIT))
         wait_d = wait_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) wait_q <= '0;
      else        wait_q <= wait_d;
   end
`else
   assign force_b = 1'b0;
`endif

   assign a_ready = reset & ~force_b;
   assign a_win   = a_valid & a_ready;
   assign drain   = reset & (count_q != '0) & ~a_win;
   assign b_ready = reset & (count_q < CW'(DEPTH));
   assign enq     = b_valid & b_ready & (b_reg != '0);

   always_comb begin
      fifo_reg_d  = fifo_reg_q;
      fifo_data_d = fifo_data_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      if (enq) begin
         fifo_reg_d[tail_q]  = b_reg;
         fifo_data_d[tail_q] = b_data;
         tail_d              = tail_q + 1'b1;
      end
      if (drain)
         head_d = head_q + 1'b1;
      case ({enq, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // wreg/wdata hold their last value on idle cycles; regwrite alone qualifies them.
   always_comb begin
      regwrite_d = 1'b0;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      if (a_win) begin
         regwrite_d = (a_reg != '0);
         wreg_d     = a_reg;
         wdata_d    = a_data;
      end else if (drain) begin
         regwrite_d = 1'b1;
         wreg_d     = fifo_reg_q[head_q];
         wdata_d    = fifo_data_q[head_q];
      end
   end

   always_comb begin
      qpending = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count_q && fifo_reg_q[head_q + PW'(i)] == qreg)
            qpending = 1'b1;
      end
      if (regwrite_q && wreg_q == qreg)
         qpending = 1'b1;
      if (qreg == '0)
         qpending = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_reg_q[i]  <= '0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         regwrite_q  <= regwrite_d;
         wreg_q      <= wreg_d;
         wdata_q     <= wdata_d;
         fifo_reg_q  <= fifo_reg_d;
         fifo_data_q <= fifo_data_d;
      end
   end

   assign regwrite = regwrite_q;
   assign wreg     = wreg_q;
   assign wdata    = wdata_q;
   assign count    = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; the fairness scenario runs when WB_FAIR_EN is defined,
// the priority/fill scenario when it is not.
`timescale 1ns/1ps
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, a_ready;
   logic [4:0]  a_reg;
   logic [31:0] a_data;
   logic        b_valid, b_ready;
   logic [4:0]  b_reg;
   logic [31:0] b_data;
   logic        regwrite;
   logic [4:0]  wreg;
   logic [31:0] wdata;
   logic [4:0]  qreg;
   logic        qpending;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   wb_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .regwrite(regwrite), .wreg(wreg), .wdata(wdata),
      .qreg(qreg), .qpending(qpending), .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h1;
      b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h2; qreg = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0b expected 0", regwrite); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %0b expected 0", a_ready); end
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %0b expected 0", b_ready); end
      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_a_path();
      a_valid = 1'b1; a_reg = 5'd1; a_data = 32'd14;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_ready: got %0b expected 1", a_ready); end
      step();
      checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL a_regwrite: got %0b expected 1", regwrite); end
      checks++; if (wreg !== 5'd1) begin errors++; $display("FAIL a_wreg: got %0d expected 1", wreg); end
      checks++; if (wdata !== 32'd14) begin errors++; $display("FAIL a_wdata: got %0d expected 14", wdata); end
      a_reg = 5'd0; a_data = 32'd99;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_r0_ready: got %0b expected 1", a_ready); end
      step();
      checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL a_r0_regwrite: got %0b expected 0", regwrite); end
      a_valid = 1'b0;
   endtask

   task automatic test_b_zero();
      b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hDEAD;
      #1;
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL bzero_ready: got %0b expected 1", b_ready); end
      step();
      b_valid = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL bzero_count: got %0d expected 0", count); end
      step();
      checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL bzero_regwrite: got %0b expected 0", regwrite); end
   endtask

   task automatic test_b_fill();
      a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99;
      for (int k = 0; k < 4; k++) begin
         b_valid = 1'b1; b_reg = 5'(2 + k); b_data = 32'(32'hA + k);
         #1;
         checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL fill_b_ready%0d: got %0b expected 1", k, b_ready); end
         step();
      end
      b_reg = 5'd6; b_data = 32'hE;
      repeat (2) begin
         #1;
         checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
         checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL fill_b_ready_full: got %0b expected 0", b_ready); end
         checks++; if (regwrite !== 1'b1 || wreg !== 5'd9) begin errors++; $display("FAIL fill_a_write: got %0b/%0d expected 1/9", regwrite, wreg); end
         step();
      end
      a_valid = 1'b0;
      #1;
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_draining_b_ready: got %0b expected 0", b_ready); end
      for (int k = 0; k < 5; k++) begin
         step();
         checks++; if (regwrite !== 1'b1) begin errors++; $display("FAIL drain_regwrite%0d: got %0b expected 1", k, regwrite); end
         checks++; if (wreg !== 5'(2 + k)) begin errors++; $display("FAIL drain_wreg%0d: got %0d expected %0d", k, wreg, 2 + k); end
         checks++; if (wdata !== 32'(32'hA + k)) begin errors++; $display("FAIL drain_wdata%0d: got %0h expected %0h", k, wdata, 32'hA + k); end
         if (k == 0) begin
            checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL drain_b_ready: got %0b expected 1", b_ready); end
         end
         if (k == 1) begin
            checks++; if (count !== 3'd3) begin errors++; $display("FAIL enq_deq_count: got %0d expected 3", count); end
            b_valid = 1'b0;
         end
      end
      step();
      checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL drain_idle: got %0b expected 0", regwrite); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
   endtask

   task automatic test_fairness();
      a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99;
      b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h33;
      step();
      b_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         checks++; if (a_ready !== (c != 4)) begin errors++; $display("FAIL fair_a_ready%0d: got %0b expected %0b", c, a_ready, c != 4); end
         checks++; if (regwrite !== 1'b1 || wreg !== 5'd9) begin errors++; $display("FAIL fair_a_write%0d: got %0b/%0d expected 1/9", c, regwrite, wreg); end
         step();
      end
      checks++; if (regwrite !== 1'b1 || wreg !== 5'd3 || wdata !== 32'h33) begin
         errors++; $display("FAIL fair_b_write: got %0b/%0d/%0h expected 1/3/33", regwrite, wreg, wdata); end
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL fair_a_ready_after: got %0b expected 1", a_ready); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL fair_count: got %0d expected 0", count); end
      a_valid = 1'b0;
      step();
   endtask

   task automatic test_query();
      a_valid = 1'b0; qreg = 5'd7;
      b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h55;
      #1;
      checks++; if (qpending !== 1'b0) begin errors++; $display("FAIL q_before: got %0b expected 0", qpending); end
      step();
      b_valid = 1'b0;
      #1;
      checks++; if (qpending !== 1'b1) begin errors++; $display("FAIL q_queued: got %0b expected 1", qpending); end
      qreg = 5'd0; #1;
      checks++; if (qpending !== 1'b0) begin errors++; $display("FAIL q_zero: got %0b expected 0", qpending); end
      qreg = 5'd8; #1;
      checks++; if (qpending !== 1'b0) begin errors++; $display("FAIL q_other: got %0b expected 0", qpending); end
      qreg = 5'd7;
      step();
      checks++; if (regwrite !== 1'b1 || wreg !== 5'd7 || wdata !== 32'h55) begin
         errors++; $display("FAIL q_write: got %0b/%0d/%0h expected 1/7/55", regwrite, wreg, wdata); end
      checks++; if (qpending !== 1'b1) begin errors++; $display("FAIL q_outstage: got %0b expected 1", qpending); end
      step();
      checks++; if (qpending !== 1'b0) begin errors++; $display("FAIL q_after: got %0b expected 0", qpending); end
   endtask

   task automatic test_reset_mid();
      a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99;
      for (int k = 0; k < 3; k++) begin
         b_valid = 1'b1; b_reg = 5'(10 + k); b_data = 32'(32'h100 + k);
         step();
      end
      b_valid = 1'b0;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count_pre: got %0d expected 3", count); end
      reset = 1'b0; #1;
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++; $display("FAIL mid_ready: got %0b/%0b expected 0/0", a_ready, b_ready); end
      step();
      reset = 1'b1; a_valid = 1'b0; qreg = 5'd10;
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
      checks++; if (regwrite !== 1'b0 || wreg !== 5'd0 || wdata !== 32'd0) begin
         errors++; $display("FAIL mid_out: got %0b/%0d/%0h expected 0/0/0", regwrite, wreg, wdata); end
      checks++; if (qpending !== 1'b0) begin errors++; $display("FAIL mid_q: got %0b expected 0", qpending); end
      for (int c = 0; c < 6; c++) begin
         step();
         checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: got %0b expected 0", c, regwrite); end
      end
   endtask

   initial begin
      test_reset();
      test_a_path();
      test_b_zero();
`ifdef WB_FAIR_EN
      test_fairness();
`else
      test_b_fill();
`endif
      test_query();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter feeding the single write port of `regfile` (`regwrite`/`wreg`/`wdata`).
- Merges two result sources into one registered write per cycle:
  - A: the in-order pipeline (ALU/load) write-back.
  - B: long-latency units (multiply/divide, uncached loads), buffered in a small FIFO.
- Also answers a pending-write query, so hazard logic can stall readers of registers not yet written.

## Interface

Clocking and reset (already decided): one clock `clk`; `reset` is synchronous and active-low.

Parameters:
- `DEPTH`, default 4: B FIFO entries; power of two, ≥2.
- `MAX_WAIT`, default 3: cycles a non-empty FIFO head may be blocked before it is forced (only with `WB_FAIR_EN`).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-low.
- `a_valid`  in  1  source A has a result this cycle.
- `a_ready`  out  1  A result accepted this cycle.
- `a_reg`  in  5  A destination register.
- `a_data`  in  32  A result.
- `b_valid`  in  1  source B offers a result.
- `b_ready`  out  1  FIFO can accept.
- `b_reg`  in  5  B destination register.
- `b_data`  in  32  B result.
- `regwrite`  out  1  write enable to regfile; registered.
- `wreg`  out  5  write register number; registered.
- `wdata`  out  32  write data; registered.
- `qreg`  in  5  register number for the pending query.
- `qpending`  out  1  a write to `qreg` is queued or in the output stage.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation

- FIFO
  - `b_ready` = (`count` < `DEPTH`); it depends on `count` only, with no pass-through.
  - Enqueue on `b_valid && b_ready`. A B result with `b_reg`==0 is accepted but not enqueued.
  - Head/tail pointers wrap modulo `DEPTH`.
- Arbitration (one winner per cycle)
  - A wins when `a_valid` and A is not blocked; `a_ready`=1 in that case.
  - Otherwise the FIFO head drains if `count`>0.
  - If nothing is selected, the next `regwrite`=0.
- Output stage
  - The winner is registered into `wreg`/`wdata`, with `regwrite`=1 on the next edge.
  - A result with `a_reg`==0 is accepted (`a_ready`=1) but produces `regwrite`=0.
- Query
  - `qpending` is combinational.
  - It is 1 if any valid FIFO entry has reg==`qreg`, or if `regwrite && wreg==qreg`.
  - `qreg`==0 always returns 0.
- Simultaneous events
  - Enqueue and dequeue in the same cycle: `count` unchanged.
  - Full FIFO draining this cycle still shows `b_ready`=0.
  - Empty FIFO: an entry enqueued this cycle drains at the earliest on the next cycle.
- Reset (`reset`=0 at an edge), also mid-operation:
  - `count`=0, pointers=0, wait counter=0.
  - `regwrite`=0, `wreg`=0, `wdata`=0.
  - Queued entries are discarded.
  - While `reset`=0, `a_ready`=0 and `b_ready`=0.

## Timing

- A: accepted in cycle N → `regwrite`/`wreg`/`wdata` valid in cycle N+1.
- B: minimum 2 cycles from acceptance to `regwrite` (enqueue in N, drain in N+1, output in N+2).
- The regfile commits at the edge ending the cycle in which `regwrite`=1.
- FIFO order is strict: B results leave in acceptance order.
- `count` and `b_ready` reflect registered state only.

## Configuration

`WB_FAIR_EN` enables the starvation guard.
- Defined:
  - A wait counter (0..`MAX_WAIT`) increments each cycle `count`>0 and the head does not drain.
  - When the counter equals `MAX_WAIT`, `a_ready`=0 and the head drains that cycle.
  - The counter clears on every drain and on reset.
- Undefined:
  - No counter; `a_ready`=1 whenever `reset`=1.
  - B drains only in cycles with `a_valid`=0.

## Test plan

- **Reset:** hold `reset`=0 two cycles with `a_valid`=1 and `b_valid`=1 → `regwrite`=0, `count`=0, `a_ready`=0, `b_ready`=0.
- **A path:** `a_valid`=1, `a_reg`=1, `a_data`=14 for one cycle → next cycle `regwrite`=1, `wreg`=1, `wdata`=14. `a_reg`=0 → `regwrite`=0.
- **B ordering and fill:**
  - Stimulus: `a_valid`=1 continuously, `WB_FAIR_EN` undefined; push B (r2,0xA), (r3,0xB), (r4,0xC), (r5,0xD), then a 5th.
  - Response: `count`=4, `b_ready`=0, 5th held.
  - Drop `a_valid` → writes r2,r3,r4,r5 on consecutive cycles with matching data.
- **Fairness:** with `WB_FAIR_EN`, `MAX_WAIT`=3, one B entry plus continuous `a_valid` → B is written on the 5th cycle after enqueue; `a_ready`=0 exactly one cycle.
- **Query:** enqueue (r7,0x55) → `qpending`=1 for `qreg`=7 until the cycle after `regwrite` with `wreg`=7; `qreg`=0 → 0.
- **Reset mid-operation:** 3 entries queued, pulse `reset`=0 one cycle → `count`=0; no stale writes appear afterwards.
